// File: rtl/probe_buffer_mc_if.sv
// Output stream of the multi-channel probe buffer: one valid/ready word
// tagged with its source channel and the variant flag.
interface probe_buffer_mc_if #(
    parameter int WIDTH = 64,
    parameter int CH_W  = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CH_W-1:0]  out_chan;
    logic             out_variant;

    modport master (
        output out_valid,
        output out_data,
        output out_chan,
        output out_variant,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_chan,
        input  out_variant,
        output out_ready
    );
endinterface

// File: rtl/probe_buffer_mc.sv
// Per-channel probe FIFOs drained round-robin through a single registered
// valid/ready output stage, with saturating per-channel overflow counters.
module probe_buffer_mc #(
    parameter int WIDTH      = 64,
    parameter int CHANNELS   = 4,
    parameter int DEPTH      = 8,
    parameter bit IS_VARIANT = 1'b0,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      flush,
    input  logic [CHANNELS-1:0]       wen,
    input  logic [CHANNELS*WIDTH-1:0] write,
    input  logic [CH_W-1:0]           rd_sel,
    output logic [WIDTH-1:0]          read,
    output logic [15:0]               drop_count,
    input  logic                      clr_drop,
    probe_buffer_mc_if.master         out_if
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q    [CHANNELS][DEPTH];
    logic [WIDTH-1:0] mem_d    [CHANNELS][DEPTH];
    logic [AW-1:0]    wr_ptr_q [CHANNELS];
    logic [AW-1:0]    wr_ptr_d [CHANNELS];
    logic [AW-1:0]    rd_ptr_q [CHANNELS];
    logic [AW-1:0]    rd_ptr_d [CHANNELS];
    logic [CNT_W-1:0] count_q  [CHANNELS];
    logic [CNT_W-1:0] count_d  [CHANNELS];
    logic [WIDTH-1:0] snap_q   [CHANNELS];
    logic [WIDTH-1:0] snap_d   [CHANNELS];
    logic [15:0]      drop_q   [CHANNELS];
    logic [15:0]      drop_d   [CHANNELS];

    logic [CH_W-1:0]  rr_q, rr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]  out_chan_q, out_chan_d;

    logic                load;
    logic                found;
    logic [CH_W-1:0]     grant;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;

    // Round-robin scan starting just after the last granted channel.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(rr_q) + k) % CHANNELS;
            if (!found && count_q[idx] != '0) begin
                found = 1'b1;
                grant = CH_W'(idx);
            end
        end
    end

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        snap_d      = snap_q;
        drop_d      = drop_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        full        = '0;
        push        = '0;
        pop         = '0;
        load        = !out_valid_q || out_if.out_ready;

        if (flush) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
            out_valid_d = 1'b0;
            rr_d        = CH_W'(CHANNELS - 1);
        end else begin
            if (load) begin
                out_valid_d = found;
                if (found) begin
                    out_data_d = mem_q[grant][rd_ptr_q[grant]];
                    out_chan_d = grant;
                    rr_d       = grant;
                end
            end
            // Fullness is judged on the pre-edge count, so a same-cycle pop never frees a slot.
            for (int i = 0; i < CHANNELS; i++) begin
                full[i] = (count_q[i] == CNT_W'(DEPTH));
                push[i] = wen[i] && enable && !full[i];
                pop[i]  = load && found && (grant == CH_W'(i));
                if (push[i]) begin
                    mem_d[i][wr_ptr_q[i]] = write[i*WIDTH +: WIDTH];
                    wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
                    snap_d[i]             = write[i*WIDTH +: WIDTH];
                end
                if (pop[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
                end
                if (push[i] && !pop[i]) begin
                    count_d[i] = count_q[i] + CNT_W'(1);
                end else if (pop[i] && !push[i]) begin
                    count_d[i] = count_q[i] - CNT_W'(1);
                end
                if (wen[i] && enable && full[i] && drop_q[i] != 16'hFFFF) begin
                    drop_d[i] = drop_q[i] + 16'd1;
                end
            end
        end

        if (clr_drop) begin
            for (int i = 0; i < CHANNELS; i++) begin
                drop_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                snap_q[i]   <= '0;
                drop_q[i]   <= '0;
            end
            rr_q        <= CH_W'(CHANNELS - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            snap_q      <= snap_d;
            drop_q      <= drop_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        read       = '0;
        drop_count = '0;
        if (int'(rd_sel) < CHANNELS) begin
            read       = snap_q[rd_sel];
            drop_count = drop_q[rd_sel];
        end
    end

    assign out_if.out_valid   = out_valid_q;
    assign out_if.out_data    = out_data_q;
    assign out_if.out_chan    = out_chan_q;
    assign out_if.out_variant = IS_VARIANT & out_valid_q;

endmodule

// File: tb/tb_probe_buffer_mc.sv
// Bench for probe_buffer_mc: a queue-based reference model predicts each drained
// word into a scoreboard that an independent monitor checks against the stream.
module tb_probe_buffer_mc;
    localparam int WIDTH    = 64;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 8;
    localparam int CH_W     = 2;

    logic                      clock;
    logic                      reset_n;
    logic                      enable;
    logic                      flush;
    logic [CHANNELS-1:0]       wen;
    logic [CHANNELS*WIDTH-1:0] write;
    logic [CH_W-1:0]           rd_sel;
    logic [WIDTH-1:0]          read;
    logic [15:0]               drop_count;
    logic                      clr_drop;

    probe_buffer_mc_if #(.WIDTH(WIDTH), .CH_W(CH_W)) out_if ();

    probe_buffer_mc #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .IS_VARIANT(1'b0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .flush(flush),
        .wen(wen), .write(write), .rd_sel(rd_sel), .read(read),
        .drop_count(drop_count), .clr_drop(clr_drop), .out_if(out_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef logic [WIDTH-1:0] word_q_t[$];
    typedef struct packed {
        logic [CH_W-1:0]  chan;
        logic [WIDTH-1:0] data;
    } item_t;

    word_q_t          fq [CHANNELS];
    logic [WIDTH-1:0] m_snap [CHANNELS];
    int               m_drop [CHANNELS];
    bit               m_valid;
    int               m_rr;
    item_t            sb[$];

    int checks  = 0;
    int passes  = 0;
    int n_acc   = 0;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFOs are plain queues, the output stage is one held item.
    task automatic model_step();
        bit full_pre [CHANNELS];
        bit load;
        int g;
        logic [WIDTH-1:0] w;
        for (int i = 0; i < CHANNELS; i++) full_pre[i] = (fq[i].size() == DEPTH);
        load = !m_valid || out_if.out_ready;
        if (flush) begin
            if (m_valid && !out_if.out_ready && sb.size() > 0) void'(sb.pop_back());
            for (int i = 0; i < CHANNELS; i++) fq[i].delete();
            m_valid = 1'b0;
            m_rr    = CHANNELS - 1;
        end else begin
            if (load) begin
                g = -1;
                for (int k = 1; k <= CHANNELS; k++) begin
                    int c;
                    c = (m_rr + k) % CHANNELS;
                    if (g < 0 && fq[c].size() > 0) g = c;
                end
                if (g >= 0) begin
                    w       = fq[g].pop_front();
                    m_valid = 1'b1;
                    m_rr    = g;
                    sb.push_back({CH_W'(g), w});
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wen[i] && enable) begin
                    w = write[i*WIDTH +: WIDTH];
                    if (full_pre[i]) begin
                        if (m_drop[i] < 65535) m_drop[i]++;
                    end else begin
                        fq[i].push_back(w);
                        m_snap[i] = w;
                    end
                end
            end
        end
        if (clr_drop) for (int i = 0; i < CHANNELS; i++) m_drop[i] = 0;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                fq[i].delete();
                m_snap[i] = '0;
                m_drop[i] = 0;
            end
            m_valid = 1'b0;
            m_rr    = CHANNELS - 1;
            sb.delete();
        end else begin
            model_step();
        end
    end

    // Monitor: runs mid-cycle, pops the scoreboard on every accepted word.
    always @(negedge clock) begin
        if (reset_n) begin
            checkOutput("out_valid", WIDTH'(out_if.out_valid), WIDTH'(m_valid));
            if (out_if.out_valid) checkOutput("out_variant", WIDTH'(out_if.out_variant), '0);
            if (out_if.out_valid && out_if.out_ready) begin
                n_acc++;
                if (sb.size() == 0) begin
                    checkOutput("spurious_word", out_if.out_data, 'x);
                end else begin
                    item_t e;
                    e = sb.pop_front();
                    checkOutput("out_chan", WIDTH'(out_if.out_chan), WIDTH'(e.chan));
                    checkOutput("out_data", out_if.out_data, e.data);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [CHANNELS-1:0] w,
                                 input logic [CHANNELS*WIDTH-1:0] d,
                                 input logic rdy, input logic en = 1'b1,
                                 input logic fl = 1'b0, input logic clr = 1'b0);
        @(posedge clock);
        #1;
        wen              = w;
        write            = d;
        out_if.out_ready = rdy;
        enable           = en;
        flush            = fl;
        clr_drop         = clr;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, rdy);
    endtask

    task automatic checkProbe(input int ch);
        rd_sel = CH_W'(ch);
        #1;
        checkOutput($sformatf("read_ch%0d", ch), read, m_snap[ch]);
        checkOutput($sformatf("drop_ch%0d", ch), WIDTH'(drop_count), WIDTH'(m_drop[ch]));
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc0;
        logic [CHANNELS*WIDTH-1:0] d;
        reset_n = 1'b0; enable = 1'b1; flush = 1'b0; clr_drop = 1'b0;
        wen = '0; write = '0; rd_sel = '0; out_if.out_ready = 1'b1;
        #23;
        reset_n = 1'b1;
        #1;
        checkOutput("reset_out_valid", WIDTH'(out_if.out_valid), '0);
        checkOutput("reset_read", read, '0);
        checkOutput("reset_drop", WIDTH'(drop_count), '0);

        // Single word: visible one edge after the push.
        applyStimulus(4'b0001, 256'hA5, 1'b1);
        applyStimulus('0, '0, 1'b1);
        rd_sel = '0;
        #1;
        checkOutput("t1_not_yet_valid", WIDTH'(out_if.out_valid), '0);
        checkOutput("t1_read", read, 64'hA5);
        applyStimulus('0, '0, 1'b1);
        #1;
        checkOutput("t1_valid", WIDTH'(out_if.out_valid), 1);
        checkOutput("t1_data", out_if.out_data, 64'hA5);
        checkOutput("t1_chan", WIDTH'(out_if.out_chan), 0);
        idle(3, 1'b1);

        // All channels at once, then again after channel 1 was last granted.
        d = {64'd3, 64'd2, 64'd1, 64'd0};
        applyStimulus(4'b1111, d, 1'b1);
        idle(6, 1'b1);
        applyStimulus(4'b0010, 256'h0, 1'b1);
        idle(3, 1'b1);
        applyStimulus(4'b1111, d, 1'b1);
        idle(6, 1'b1);

        // Overflow on channel 2 with the consumer stalled.
        for (int k = 0; k < 10; k++) begin
            d = '0;
            d[2*WIDTH +: WIDTH] = 64'h200 + 64'(k);
            applyStimulus(4'b0100, d, 1'b0);
        end
        idle(1, 1'b0);
        rd_sel = 2'd2;
        #1;
        checkOutput("t3_drop_one", WIDTH'(drop_count), 1);
        checkProbe(2);
        acc0 = n_acc;
        idle(12, 1'b1);
        checkOutput("t3_emitted", WIDTH'(n_acc - acc0), 9);

        // Saturation of channel 1's drop counter.
        for (int k = 0; k < 9 + 65534; k++) applyStimulus(4'b0010, 256'h1 << WIDTH, 1'b0);
        idle(1, 1'b0);
        rd_sel = 2'd1;
        #1;
        checkOutput("t4_fffe", WIDTH'(drop_count), 64'hFFFE);
        for (int k = 0; k < 3; k++) applyStimulus(4'b0010, 256'h1 << WIDTH, 1'b0);
        idle(1, 1'b0);
        #1;
        checkOutput("t4_saturated", WIDTH'(drop_count), 64'hFFFF);
        applyStimulus(4'b0010, 256'h1 << WIDTH, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b0);
        #1;
        checkOutput("t4_cleared", WIDTH'(drop_count), 0);
        checkProbe(2);
        idle(12, 1'b1);

        // Flush with five words waiting behind a stalled output.
        for (int k = 0; k < 5; k++) begin
            d = '0;
            d[3*WIDTH +: WIDTH] = 64'h300 + 64'(k);
            applyStimulus(4'b1000, d, 1'b0);
        end
        idle(2, 1'b0);
        d = '0;
        d[3*WIDTH +: WIDTH] = 64'hDEAD;
        applyStimulus(4'b1000, d, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        #1;
        checkOutput("t5_flushed", WIDTH'(out_if.out_valid), 0);
        acc0 = n_acc;
        idle(5, 1'b1);
        checkOutput("t5_none_after", WIDTH'(n_acc - acc0), 0);
        rd_sel = 2'd3;
        #1;
        checkOutput("t5_snapshot", read, 64'h304);

        // Asynchronous reset while draining.
        for (int k = 0; k < 4; k++) begin
            d = '0;
            d[0 +: WIDTH] = 64'h400 + 64'(k);
            applyStimulus(4'b0001, d, 1'b0);
        end
        applyStimulus('0, '0, 1'b1);
        #1;
        checkOutput("t6_draining", WIDTH'(out_if.out_valid), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_clear", WIDTH'(out_if.out_valid), 0);
        idle(2, 1'b1);
        reset_n = 1'b1;
        acc0 = n_acc;
        for (int k = 0; k < 12; k++) applyStimulus(4'b1111, {4{64'hBEEF}}, 1'b0, 1'b0);
        idle(4, 1'b1);
        checkOutput("t6_no_words", WIDTH'(n_acc - acc0), 0);
        rd_sel = 2'd0;
        #1;
        checkOutput("t6_read_cleared", read, '0);
        checkOutput("t6_no_drops", WIDTH'(drop_count), '0);

        // Randomised traffic, mixing stall-heavy and flowing phases.
        for (int k = 0; k < 3000; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            applyStimulus(CHANNELS'($urandom),
                          d,
                          (k < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 15) != 0,
                          $urandom_range(0, 63) == 0,
                          $urandom_range(0, 63) == 0);
            checkProbe($urandom_range(0, CHANNELS - 1));
        end
        idle(40, 1'b1);
        checkOutput("final_scoreboard_empty", WIDTH'(sb.size()), 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
